// File: rtl/booth4_wallace_defs_pkg.sv
// booth4_wallace_defs: shared definitions for the Booth-4/Wallace multiplier stages.
package booth4_wallace_defs;
    localparam int PROD_W_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/wallace_final_adder_seq_cpa_slice.sv
// cpa_slice: combinational W-bit carry-propagate adder slice with carry in/out.
module cpa_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/wallace_final_adder_seq.sv
// wallace_final_adder_seq: two-cycle half-width final adder for the Wallace sum/carry rows.
// Optional macro CPA_COUT_EN adds the cout port for the carry out of the top bit.
module wallace_final_adder_seq
    import booth4_wallace_defs::*;
#(
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] sum_vec,
    input  logic [PROD_W-1:0] carry_vec,
    output logic [PROD_W-1:0] prod,
    output logic              out_valid,
`ifdef CPA_COUT_EN
    output logic              cout,
`endif
    input  logic              out_ready
);
    localparam int H = PROD_W / 2;
    state_t            state_q, state_d;
    logic [PROD_W-1:0] sum_q, sum_d, carry_q, carry_d, prod_q, prod_d;
    logic              c_q, c_d, valid_q, valid_d, cout_q, cout_d;
    logic [H-1:0]      op_a, op_b, slice_s;
    logic              op_cin, slice_cout;
    // One slice serves both halves; the state selects which half feeds it.
    assign op_a   = (state_q == HIGH) ? sum_q[PROD_W-1:H] : sum_q[H-1:0];
    assign op_b   = (state_q == HIGH) ? carry_q[PROD_W-1:H] : carry_q[H-1:0];
    assign op_cin = (state_q == HIGH) ? c_q : 1'b0;
    cpa_slice #(.W(H)) u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .s    (slice_s),
        .cout (slice_cout)
    );
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        prod_d  = prod_q;
        c_d     = c_q;
        valid_d = valid_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sum_d   = sum_vec;
                carry_d = carry_vec;
                state_d = LOW;
            end
            LOW: begin
                prod_d[H-1:0] = slice_s;
                c_d           = slice_cout;
                state_d       = HIGH;
            end
            HIGH: begin
                prod_d[PROD_W-1:H] = slice_s;
                cout_d             = slice_cout;
                valid_d            = 1'b1;
                state_d            = DONE;
            end
            DONE: if (out_ready) begin
                valid_d = 1'b0;
                cout_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end
`ifdef CPA_COUT_EN
    always_ff @(posedge clk) begin
        if (rst) cout_q <= 1'b0;
        else     cout_q <= cout_d;
    end
    assign cout = cout_q;
`else
    assign cout_q = 1'b0;
`endif
    assign in_ready  = (state_q == IDLE);
    assign prod      = prod_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_wallace_final_adder_seq.sv
// tb_wallace_final_adder_seq: randomized scoreboard bench for wallace_final_adder_seq.
module tb_wallace_final_adder_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] sum_vec = '0;
    logic [31:0] carry_vec = '0;
    logic [31:0] prod;
    logic        out_valid;
    logic        out_ready = 1'b1;
`ifdef CPA_COUT_EN
    logic        cout;
`endif
    logic [32:0] exp_q[$];
    int          pass_cnt = 0, total_cnt = 0;
    int          n_acc = 0, n_out = 0, n_drop = 0;
    int          cyc = 0, last_acc = -1, b2b_acc = 0;
    bit          b2b = 1'b0;

    wallace_final_adder_seq #(.PROD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .prod      (prod),
        .out_valid (out_valid),
`ifdef CPA_COUT_EN
        .cout      (cout),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [32:0] model(input logic [31:0] s, input logic [31:0] c);
        return {1'b0, s} + {1'b0, c};
    endfunction

    // Acceptance side of the scoreboard: expected result queued at each handshake.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(sum_vec, carry_vec));
            n_acc++;
            if (b2b) begin
                if (last_acc >= 0) chk("b2b_interval", 64'(cyc - last_acc), 64'd4);
                last_acc = cyc;
                b2b_acc++;
            end
        end
    end

    // Monitor: pops and compares on each output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [32:0] e;
            n_out++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got %0h expected none", prod);
            end else begin
                e = exp_q.pop_front();
                chk("prod", 64'(prod), 64'(e[31:0]));
`ifdef CPA_COUT_EN
                chk("cout", 64'(cout), 64'(e[32]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [31:0] s, input logic [31:0] c);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_vec   = s;
        carry_vec = c;
        @(negedge clk) chk("accept_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk) chk("lat_edge1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk) chk("lat_edge2", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk) chk("lat_edge3", 64'(out_valid), 64'd1);
        tick();
        @(negedge clk) begin
            chk("idle_ready", 64'(in_ready), 64'd1);
            chk("idle_valid", 64'(out_valid), 64'd0);
        end
        tick();
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] s, c;
        int          n;
        tick();
        tick();
        @(negedge clk) begin
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_prod", 64'(prod), 64'd0);
        end
        tick();
        rst = 1'b0;
        tick();
        run_one(32'h0000FFFF, 32'h00000001);
        run_one(32'hFFFFFFF0, 32'h00000001);
        run_one(32'hFFFFFFFF, 32'h00000001);
        run_one(32'h12345678, 32'h8765432F);
        // Backpressure: result must hold while the consumer stalls.
        s = $urandom;
        c = $urandom;
        e = model(s, c);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_vec   = s;
        carry_vec = c;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            sum_vec   = $urandom;
            carry_vec = $urandom;
            @(negedge clk) begin
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_prod", 64'(prod), 64'(e[31:0]));
                chk("bp_in_ready", 64'(in_ready), 64'd0);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk) begin
            chk("bp_release_ready", 64'(in_ready), 64'd1);
            chk("bp_release_valid", 64'(out_valid), 64'd0);
        end
        tick();
        // Reset while in HIGH drops the operation.
        in_valid  = 1'b1;
        sum_vec   = 32'hAAAA5555;
        carry_vec = 32'h11112222;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk) begin
            chk("rstH_out_valid", 64'(out_valid), 64'd0);
            chk("rstH_prod", 64'(prod), 64'd0);
            chk("rstH_in_ready", 64'(in_ready), 64'd1);
`ifdef CPA_COUT_EN
            chk("rstH_cout", 64'(cout), 64'd0);
`endif
            exp_q.delete();
            n_drop++;
        end
        tick();
        rst = 1'b0;
        run_one(32'h0F0F0F0F, 32'hF0F0F0F1);
        // Back-to-back with in_valid held high.
        b2b       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (b2b_acc < 20 && n < 200) begin
            sum_vec   = $urandom;
            carry_vec = $urandom;
            tick();
            n++;
        end
        chk("b2b_accepts", 64'(b2b_acc), 64'd20);
        in_valid = 1'b0;
        b2b      = 1'b0;
        repeat (6) tick();
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            sum_vec   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            carry_vec = $urandom;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("out_count", 64'(n_out), 64'(n_acc - n_drop));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
